// File: rtl/maze_grid_controller.sv
// Tile-state controller for the maze display: takes one-byte tile updates from
// the Arduino over a 4-phase valid/ack handshake, holds the tile store and the
// robot position, and returns a registered RGB332 colour for each VGA pixel.
module maze_grid_controller #(
  parameter int GRID_W  = 5,
  parameter int GRID_H  = 4,
  parameter int TILE_PX = 120
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic [7:0] ARD_DATA,
  input  logic       ARD_VALID,
  output logic       ARD_ACK,
  input  logic [9:0] PIXEL_X,
  input  logic [9:0] PIXEL_Y,
  output logic [7:0] PIXEL_COLOR,
  output logic [3:0] ERR_COUNT,
  output logic [7:0] PKT_COUNT
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WRITE    = 2'd1,
    ST_WAIT_LOW = 2'd2
  } state_t;

  state_t     state;
  logic       valid_sync1;
  logic       valid_sync2;
  logic [7:0] pkt_byte;
  logic [2:0] tiles [GRID_H][GRID_W];
  logic [1:0] robot_row;
  logic [2:0] robot_col;

  logic [1:0] pkt_row;
  logic [2:0] pkt_col;
  logic [2:0] pkt_code;
  logic       pkt_clear;
  logic       pkt_in_grid;

  logic [3:0] pix_col;
  logic [3:0] pix_row;
  logic [2:0] pix_tile;
  logic       pix_in_grid;
  logic       pix_on_robot;
  logic [7:0] color_p0;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic [7:0] palette(input logic [2:0] code);
    case (code)
      3'd0:    palette = 8'b010_010_01;
      3'd1:    palette = 8'b000_111_00;
      3'd2:    palette = 8'b000_000_11;
      3'd3:    palette = 8'b111_111_00;
      3'd4:    palette = 8'b111_000_11;
      3'd5:    palette = 8'b000_111_11;
      3'd6:    palette = 8'b111_111_11;
      default: palette = 8'h00;
    endcase
  endfunction

  assign pkt_row     = pkt_byte[7:6];
  assign pkt_col     = pkt_byte[5:3];
  assign pkt_code    = pkt_byte[2:0];
  assign pkt_clear   = (pkt_byte == 8'hFF);
  assign pkt_in_grid = (int'(pkt_row) < GRID_H) && (int'(pkt_col) < GRID_W);

  // Two-flop synchronizer for the asynchronous Arduino request
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      valid_sync1 <= 1'b0;
      valid_sync2 <= 1'b0;
    end else begin
      valid_sync1 <= ARD_VALID;
      valid_sync2 <= valid_sync1;
    end
  end

  // Packet capture; ARD_DATA has been stable for two cycles once sync2 is seen high
  always_ff @(posedge CLOCK) begin
    if (state == ST_IDLE && valid_sync2)
      pkt_byte <= ARD_DATA;
  end

  // Handshake FSM, tile store, robot register and packet counters
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state     <= ST_IDLE;
      ARD_ACK   <= 1'b0;
      ERR_COUNT <= '0;
      PKT_COUNT <= '0;
      robot_row <= '0;
      robot_col <= '0;
      for (int r = 0; r < GRID_H; r++)
        for (int c = 0; c < GRID_W; c++)
          tiles[r][c] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (valid_sync2)
            state <= ST_WRITE;
        end
        ST_WRITE: begin
          ARD_ACK <= 1'b1;
          state   <= ST_WAIT_LOW;
          if (pkt_clear) begin
            PKT_COUNT <= PKT_COUNT + 8'd1;
            robot_row <= '0;
            robot_col <= '0;
            for (int r = 0; r < GRID_H; r++)
              for (int c = 0; c < GRID_W; c++)
                tiles[r][c] <= '0;
          end else if (!pkt_in_grid) begin
            // Out-of-grid packets are still acknowledged, only counted as errors
            ERR_COUNT <= sat_inc4(ERR_COUNT);
          end else begin
            PKT_COUNT <= PKT_COUNT + 8'd1;
            if (pkt_code == 3'd7) begin
              robot_row <= pkt_row;
              robot_col <= pkt_col;
            end
            for (int r = 0; r < GRID_H; r++)
              for (int c = 0; c < GRID_W; c++)
                if (int'(pkt_row) == r && int'(pkt_col) == c)
                  tiles[r][c] <= (pkt_code == 3'd7) ? 3'd1 : pkt_code;
          end
        end
        ST_WAIT_LOW: begin
          if (!valid_sync2) begin
            ARD_ACK <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: begin
          ARD_ACK <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  // Pixel to tile index: count passed tile boundaries instead of dividing.
  // Any quotient of 8 or more lands on 8, which is outside every legal grid.
  always_comb begin
    pix_col = '0;
    pix_row = '0;
    for (int i = 1; i <= 8; i++) begin
      if (int'(PIXEL_X) >= i * TILE_PX) pix_col = 4'(i);
      if (int'(PIXEL_Y) >= i * TILE_PX) pix_row = 4'(i);
    end
  end

  // Tile lookup and colour selection, robot overriding the palette
  always_comb begin
    pix_tile    = '0;
    pix_in_grid = 1'b0;
    for (int r = 0; r < GRID_H; r++)
      for (int c = 0; c < GRID_W; c++)
        if (int'(pix_row) == r && int'(pix_col) == c) begin
          pix_tile    = tiles[r][c];
          pix_in_grid = 1'b1;
        end
    pix_on_robot = (pix_row == {2'b00, robot_row}) && (pix_col == {1'b0, robot_col});
    if (!pix_in_grid)
      color_p0 = 8'h00;
    else if (pix_on_robot)
      color_p0 = 8'b111_000_00;
    else
      color_p0 = palette(pix_tile);
  end

  // ---- stage p0 -> p1: registered colour, reads the tile state before any same-edge write
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET)
      PIXEL_COLOR <= '0;
    else
      PIXEL_COLOR <= color_p0;
  end

endmodule

// File: tb/tb_maze_grid_controller.sv
// Testbench for maze_grid_controller: constant vector table, hand-written
// handshake/reset sequences, and randomized packets against a reference model.
module tb_maze_grid_controller;

  localparam int GRID_W  = 5;
  localparam int GRID_H  = 4;
  localparam int TILE_PX = 120;

  logic       CLOCK;
  logic       RESET;
  logic [7:0] ARD_DATA;
  logic       ARD_VALID;
  logic       ARD_ACK;
  logic [9:0] PIXEL_X;
  logic [9:0] PIXEL_Y;
  logic [7:0] PIXEL_COLOR;
  logic [3:0] ERR_COUNT;
  logic [7:0] PKT_COUNT;

  maze_grid_controller #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H),
    .TILE_PX(TILE_PX)
  ) dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .ARD_DATA   (ARD_DATA),
    .ARD_VALID  (ARD_VALID),
    .ARD_ACK    (ARD_ACK),
    .PIXEL_X    (PIXEL_X),
    .PIXEL_Y    (PIXEL_Y),
    .PIXEL_COLOR(PIXEL_COLOR),
    .ERR_COUNT  (ERR_COUNT),
    .PKT_COUNT  (PKT_COUNT)
  );

  initial CLOCK = 1'b0;
  always #20 CLOCK = ~CLOCK;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int         m_tile [GRID_H][GRID_W];
  int         m_rr;
  int         m_rc;
  int         m_err;
  logic [7:0] m_pkt;

  typedef struct {
    bit         send;
    logic [7:0] data;
    int         px;
    int         py;
    logic [7:0] exp_color;
    logic [7:0] exp_pkt;
    logic [3:0] exp_err;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic void model_reset();
    for (int r = 0; r < GRID_H; r++)
      for (int c = 0; c < GRID_W; c++)
        m_tile[r][c] = 0;
    m_rr  = 0;
    m_rc  = 0;
    m_err = 0;
    m_pkt = 8'd0;
  endfunction

  function automatic void model_apply(input logic [7:0] d);
    int row, col, code;
    row  = int'(d[7:6]);
    col  = int'(d[5:3]);
    code = int'(d[2:0]);
    if (d == 8'hFF) begin
      for (int r = 0; r < GRID_H; r++)
        for (int c = 0; c < GRID_W; c++)
          m_tile[r][c] = 0;
      m_rr  = 0;
      m_rc  = 0;
      m_pkt = m_pkt + 8'd1;
    end else if (row >= GRID_H || col >= GRID_W) begin
      if (m_err < 15) m_err = m_err + 1;
    end else begin
      if (code == 7) begin
        m_rr = row;
        m_rc = col;
        m_tile[row][col] = 1;
      end else begin
        m_tile[row][col] = code;
      end
      m_pkt = m_pkt + 8'd1;
    end
  endfunction

  function automatic logic [7:0] model_color(input int x, input int y);
    int col, row;
    col = x / TILE_PX;
    row = y / TILE_PX;
    if (col >= GRID_W || row >= GRID_H) return 8'h00;
    if (row == m_rr && col == m_rc) return 8'b111_000_00;
    case (m_tile[row][col])
      0:       return 8'b010_010_01;
      1:       return 8'b000_111_00;
      2:       return 8'b000_000_11;
      3:       return 8'b111_111_00;
      4:       return 8'b111_000_11;
      5:       return 8'b000_111_11;
      6:       return 8'b111_111_11;
      default: return 8'h00;
    endcase
  endfunction

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  // Full 4-phase transfer; checks the acknowledge latencies and updates the model
  task automatic send_pkt(input logic [7:0] d);
    int n;
    ARD_DATA  = d;
    ARD_VALID = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!ARD_ACK && n < 12);
    check("ack_rise_latency", 32'(n), 32'd4);
    ARD_VALID = 1'b0;
    n = 0;
    do begin tick(); n++; end while (ARD_ACK && n < 12);
    check("ack_fall_latency", 32'(n), 32'd3);
    model_apply(d);
  endtask

  task automatic probe(input int x, input int y, output logic [7:0] c);
    PIXEL_X = 10'(x);
    PIXEL_Y = 10'(y);
    tick();
    c = PIXEL_COLOR;
  endtask

  task automatic scan_tiles(input string tag);
    logic [7:0] c;
    int x, y;
    for (int r = 0; r < GRID_H; r++)
      for (int k = 0; k < GRID_W; k++) begin
        x = k * TILE_PX + TILE_PX / 2;
        y = r * TILE_PX + TILE_PX / 2;
        probe(x, y, c);
        check(tag, 32'(c), 32'(model_color(x, y)));
      end
  endtask

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] c;
    logic [7:0] pkt0;
    int         n;
    bit         hold_ok;

    tbl[0]  = '{1'b1, 8'h53,   0,   0 + 250 - 250 + 250, 8'hFC, 8'd1, 4'd0};
    tbl[0].px = 250; tbl[0].py = 130;
    tbl[1]  = '{1'b1, 8'h9F, 370, 250, 8'hE0, 8'd2, 4'd0};
    tbl[2]  = '{1'b0, 8'h00,  10,  10, 8'h49, 8'd2, 4'd0};
    tbl[3]  = '{1'b1, 8'h0F, 370, 250, 8'h1C, 8'd3, 4'd0};
    tbl[4]  = '{1'b0, 8'h00, 130,   5, 8'hE0, 8'd3, 4'd0};
    tbl[5]  = '{1'b1, 8'h31, 250, 130, 8'hFC, 8'd3, 4'd1};
    tbl[6]  = '{1'b1, 8'hE4, 599, 479, 8'hE3, 8'd4, 4'd1};
    tbl[7]  = '{1'b1, 8'hEA, 600, 479, 8'h00, 8'd4, 4'd2};
    tbl[8]  = '{1'b1, 8'h06,   0,   0, 8'hFF, 8'd5, 4'd2};
    tbl[9]  = '{1'b1, 8'h20, 480,   0, 8'h49, 8'd6, 4'd2};
    tbl[10] = '{1'b1, 8'h45,   0, 120, 8'h1F, 8'd7, 4'd2};
    tbl[11] = '{1'b1, 8'h82, 119, 359, 8'h03, 8'd8, 4'd2};

    RESET     = 1'b1;
    ARD_VALID = 1'b0;
    ARD_DATA  = 8'h00;
    PIXEL_X   = 10'd0;
    PIXEL_Y   = 10'd0;
    repeat (3) @(posedge CLOCK);
    #1;
    check("reset_ack", 32'(ARD_ACK), 32'd0);
    check("reset_color", 32'(PIXEL_COLOR), 32'd0);
    check("reset_err", 32'(ERR_COUNT), 32'd0);
    check("reset_pkt", 32'(PKT_COUNT), 32'd0);
    RESET = 1'b0;
    model_reset();

    // Power-up picture
    probe(0, 0, c);
    check("init_robot_px", 32'(c), 32'hE0);
    probe(600, 0, c);
    check("init_outside_x", 32'(c), 32'h00);
    probe(0, 480, c);
    check("init_outside_y", 32'(c), 32'h00);
    probe(599, 479, c);
    check("init_last_px", 32'(c), 32'h49);
    scan_tiles("init_scan");

    // Vector table
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].send) send_pkt(tbl[i].data);
      probe(tbl[i].px, tbl[i].py, c);
      check($sformatf("vec%0d_color", i), 32'(c), 32'(tbl[i].exp_color));
      check($sformatf("vec%0d_pkt", i), 32'(PKT_COUNT), 32'(tbl[i].exp_pkt));
      check($sformatf("vec%0d_err", i), 32'(ERR_COUNT), 32'(tbl[i].exp_err));
    end

    // Error counter saturation
    for (int i = 0; i < 20; i++) send_pkt(8'h31);
    check("err_saturated", 32'(ERR_COUNT), 32'd15);
    check("err_pkt_unchanged", 32'(PKT_COUNT), 32'd8);
    probe(250, 130, c);
    check("err_tile_unchanged", 32'(c), 32'hFC);

    // Read-before-write on the write edge
    PIXEL_X   = 10'd130;
    PIXEL_Y   = 10'd130;
    ARD_DATA  = 8'h4B;
    ARD_VALID = 1'b1;
    repeat (4) tick();
    check("rbw_ack", 32'(ARD_ACK), 32'd1);
    check("rbw_old_color", 32'(PIXEL_COLOR), 32'h49);
    tick();
    check("rbw_new_color", 32'(PIXEL_COLOR), 32'hFC);
    ARD_VALID = 1'b0;
    n = 0;
    do begin tick(); n++; end while (ARD_ACK && n < 12);
    check("rbw_fall_latency", 32'(n), 32'd3);
    model_apply(8'h4B);

    // Long valid pulse: one packet only
    pkt0      = PKT_COUNT;
    ARD_DATA  = 8'h5A;
    ARD_VALID = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!ARD_ACK && n < 12);
    check("hold_rise_latency", 32'(n), 32'd4);
    hold_ok = 1'b1;
    for (int i = 0; i < 46; i++) begin
      tick();
      if (!ARD_ACK) hold_ok = 1'b0;
    end
    check("hold_ack_high", 32'(hold_ok), 32'd1);
    check("hold_single_pkt", 32'(PKT_COUNT), 32'(pkt0 + 8'd1));
    ARD_VALID = 1'b0;
    n = 0;
    do begin tick(); n++; end while (ARD_ACK && n < 12);
    check("hold_fall_latency", 32'(n), 32'd3);
    model_apply(8'h5A);
    scan_tiles("pre_reset_scan");

    // Reset while waiting for valid to drop
    ARD_DATA  = 8'hE5;
    ARD_VALID = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!ARD_ACK && n < 12);
    check("rst_mid_rise", 32'(n), 32'd4);
    #5;
    RESET = 1'b1;
    #1;
    check("rst_mid_ack_drop", 32'(ARD_ACK), 32'd0);
    check("rst_mid_pkt", 32'(PKT_COUNT), 32'd0);
    check("rst_mid_err", 32'(ERR_COUNT), 32'd0);
    @(posedge CLOCK);
    @(posedge CLOCK);
    #1;
    check("rst_mid_color", 32'(PIXEL_COLOR), 32'd0);
    RESET = 1'b0;
    model_reset();
    n = 0;
    do begin tick(); n++; end while (!ARD_ACK && n < 12);
    check("rst_reapply_rise", 32'(n), 32'd4);
    model_apply(8'hE5);
    check("rst_reapply_pkt", 32'(PKT_COUNT), 32'd1);
    ARD_VALID = 1'b0;
    n = 0;
    do begin tick(); n++; end while (ARD_ACK && n < 12);
    check("rst_reapply_fall", 32'(n), 32'd3);
    scan_tiles("post_reset_scan");

    // CLEAR after moving the robot away
    send_pkt(8'h9F);
    send_pkt(8'hFF);
    check("clear_pkt", 32'(PKT_COUNT), 32'd3);
    probe(0, 0, c);
    check("clear_robot_home", 32'(c), 32'hE0);
    probe(370, 250, c);
    check("clear_old_robot", 32'(c), 32'h49);
    scan_tiles("clear_scan");

    // Randomized packets against the model
    for (int i = 0; i < 300; i++) begin
      logic [7:0] d;
      int x, y;
      d = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom);
      send_pkt(d);
      x = int'($urandom_range(0, 700));
      y = int'($urandom_range(0, 520));
      probe(x, y, c);
      check("rand_color", 32'(c), 32'(model_color(x, y)));
      check("rand_pkt", 32'(PKT_COUNT), 32'(m_pkt));
      check("rand_err", 32'(ERR_COUNT), 32'(m_err));
    end

    // Packet counter wrap
    for (int i = 0; i < 300 && m_pkt != 8'hFF; i++) send_pkt(8'h00);
    check("wrap_at_255", 32'(PKT_COUNT), 32'hFF);
    send_pkt(8'h13);
    check("wrap_to_0", 32'(PKT_COUNT), 32'd0);
    scan_tiles("final_scan");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
